// File: rtl/flash_cmd_pkg.sv
// Shared definitions for the flash write-path sequencer: state encoding,
// command codes and the default unlock/command byte values.
package flash_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UNLK1 = 3'd1,
        ST_UNLK2 = 3'd2,
        ST_CMD   = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] CODE_PROG  = 3'd0;
    localparam logic [2:0] CODE_ERASE = 3'd1;
    localparam logic [2:0] CODE_READ  = 3'd2;
    localparam logic [2:0] CODE_STAT  = 3'd3;

    localparam logic [7:0] DEF_UNLOCK1   = 8'hAA;
    localparam logic [7:0] DEF_UNLOCK2   = 8'h55;
    localparam logic [7:0] DEF_CMD_PROG  = 8'hB0;
    localparam logic [7:0] DEF_CMD_ERASE = 8'hC0;
    localparam logic [7:0] DEF_CMD_READ  = 8'hD0;
    localparam logic [7:0] DEF_CMD_STAT  = 8'hE0;

    // Codes above STAT are reserved and rejected at start.
    function automatic logic code_valid(input logic [2:0] code);
        return code <= CODE_STAT;
    endfunction

endpackage

// File: rtl/flash_byte_reg.sv
// Output holding register with valid flag: load sets valid, clear drops it,
// the byte itself is kept until the next load.
module flash_byte_reg #(
    parameter int DATA_W = 8
) (
    input  logic              SCL,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(negedge SCL) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/flash_cmd_seq_mux.sv
// Write-path byte sequencer: unlock prefix, command byte, then (program only)
// a payload burst, each byte handed to the transmitter with valid/ack.
module flash_cmd_seq_mux
    import flash_cmd_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter int              LEN_W     = 5,
    parameter logic [DATA_W-1:0] UNLOCK1   = DEF_UNLOCK1,
    parameter logic [DATA_W-1:0] UNLOCK2   = DEF_UNLOCK2,
    parameter logic [DATA_W-1:0] CMD_PROG  = DEF_CMD_PROG,
    parameter logic [DATA_W-1:0] CMD_ERASE = DEF_CMD_ERASE,
    parameter logic [DATA_W-1:0] CMD_READ  = DEF_CMD_READ,
    parameter logic [DATA_W-1:0] CMD_STAT  = DEF_CMD_STAT
) (
    input  logic              SCL,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        cmd_code,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              byte_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              load, clear, ack;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] cmd_byte;

    always_comb begin
        case (cmd_q)
            CODE_PROG:  cmd_byte = CMD_PROG;
            CODE_ERASE: cmd_byte = CMD_ERASE;
            CODE_READ:  cmd_byte = CMD_READ;
            default:    cmd_byte = CMD_STAT;
        endcase
    end

    // An ack only counts while a byte is actually on offer.
    assign ack        = byte_ack && out_valid;
    assign data_ready = (state_q == ST_DATA) && !out_valid && (count_q < len_q);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        count_d   = count_q;
        err_d     = 1'b0;
        load      = 1'b0;
        clear     = 1'b0;
        load_data = data_in;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!code_valid(cmd_code) ||
                        (cmd_code == CODE_PROG && burst_len == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        cmd_d     = cmd_code;
                        len_d     = burst_len;
                        count_d   = '0;
                        load      = 1'b1;
                        load_data = UNLOCK1;
                        state_d   = ST_UNLK1;
                    end
                end
            end
            ST_UNLK1: begin
                if (ack) begin
                    load      = 1'b1;
                    load_data = UNLOCK2;
                    state_d   = ST_UNLK2;
                end
            end
            ST_UNLK2: begin
                if (ack) begin
                    load      = 1'b1;
                    load_data = cmd_byte;
                    state_d   = ST_CMD;
                end
            end
            ST_CMD: begin
                if (ack) begin
                    clear   = 1'b1;
                    state_d = (cmd_q == CODE_PROG) ? ST_DATA : ST_DONE;
                end
            end
            ST_DATA: begin
                if (data_valid && data_ready) begin
                    load    = 1'b1;
                    count_d = count_q + 1'b1;
                end else if (ack) begin
                    clear = 1'b1;
                    if (count_q == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats any ack or load decided above.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            load    = 1'b0;
            clear   = 1'b1;
        end
    end

    always_ff @(negedge SCL) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    flash_byte_reg #(.DATA_W(DATA_W)) u_byte_reg (
        .SCL       (SCL),
        .reset     (reset),
        .load      (load),
        .clear     (clear),
        .load_data (load_data),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

endmodule
